// File: rtl/spi_packet_rx_if.sv
// Bus bundle for the SPI packet receiver: raw MCU SPI lines in, decoded frame out.
// Handshake: ready is a one-cycle strobe with no back-pressure. spiPacket1/2 are
// valid on and after that cycle and hold until the next strobe. frameErr is a
// one-cycle strobe that is never coincident with ready.
interface spi_packet_rx_if;
  logic       sck;
  logic       sdi;
  logic       csN;
  logic [7:0] spiPacket1;
  logic [7:0] spiPacket2;
  logic       ready;
  logic       frameErr;
  logic [1:0] fsm_state;

  modport master (
    output sck, sdi, csN,
    input  spiPacket1, spiPacket2, ready, frameErr, fsm_state
  );

  modport slave (
    input  sck, sdi, csN,
    output spiPacket1, spiPacket2, ready, frameErr, fsm_state
  );
endinterface

// File: rtl/spi_packet_rx.sv
// SPI mode-0 slave receiver: oversamples sck/sdi/csN in clk and assembles
// two-byte MSB-first frames, aborting partial frames on csN release or sck timeout.
module spi_packet_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic           clk,
  input logic           reset,
  spi_packet_rx_if.slave bus
);

  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE0 = 2'd1,
    BYTE1 = 2'd2
  } state_t;

  // All three lines share one pipeline depth so data stays aligned with its clock.
  logic [SS-1:0] sck_sync, sdi_sync, csn_sync;
  logic          sck_prev;
  logic          sck_s, sdi_s, cs_s, sck_rise;

  state_t        state;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] tcnt;
  logic [7:0]    shreg;
  logic [7:0]    held;
  logic [7:0]    p1, p2;
  logic          ready_r, err_r;
  logic [7:0]    next_byte;

  assign sck_s     = sck_sync[SS-1];
  assign sdi_s     = sdi_sync[SS-1];
  assign cs_s      = csn_sync[SS-1];
  assign sck_rise  = sck_s & ~sck_prev;
  assign next_byte = {shreg[6:0], sdi_s};

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync <= '0;
      sdi_sync <= '0;
      csn_sync <= '1;
      sck_prev <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SS-2:0], bus.sck};
      sdi_sync <= {sdi_sync[SS-2:0], bus.sdi};
      csn_sync <= {csn_sync[SS-2:0], bus.csN};
      sck_prev <= sck_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= 4'd0;
      tcnt    <= '0;
      shreg   <= 8'd0;
      held    <= 8'd0;
      p1      <= 8'd0;
      p2      <= 8'd0;
      ready_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      ready_r <= 1'b0;
      err_r   <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= 4'd0;
          tcnt    <= '0;
          if (!cs_s) state <= BYTE0;
        end
        default: begin
          // The completing edge wins over a coincident csN release.
          if (sck_rise && state == BYTE1 && bit_cnt == 4'd15) begin
            p1      <= held;
            p2      <= next_byte;
            shreg   <= next_byte;
            ready_r <= 1'b1;
            bit_cnt <= 4'd0;
            tcnt    <= '0;
            state   <= cs_s ? IDLE : BYTE0;
          end else if (cs_s) begin
            if (bit_cnt != 4'd0) err_r <= 1'b1;
            bit_cnt <= 4'd0;
            tcnt    <= '0;
            state   <= IDLE;
          end else if (sck_rise) begin
            shreg   <= next_byte;
            bit_cnt <= bit_cnt + 4'd1;
            tcnt    <= '0;
            if (bit_cnt == 4'd7) begin
              held  <= next_byte;
              state <= BYTE1;
            end
          end else if (bit_cnt == 4'd0) begin
            tcnt <= '0;
          end else if (tcnt == TLIM) begin
            err_r   <= 1'b1;
            bit_cnt <= 4'd0;
            tcnt    <= '0;
            state   <= BYTE0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
      endcase
    end
  end

  assign bus.spiPacket1 = p1;
  assign bus.spiPacket2 = p2;
  assign bus.ready      = ready_r;
  assign bus.frameErr   = err_r;
  assign bus.fsm_state  = state;

endmodule
